// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared card/score types, card codes, draw-rule defaults and sequencer states.
package baccarat_pkg;

    typedef logic [3:0] card_t;
    typedef logic [3:0] score_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_NINE  = 4'd9;
    localparam card_t CARD_TEN   = 4'd10;
    localparam card_t CARD_JACK  = 4'd11;
    localparam card_t CARD_QUEEN = 4'd12;
    localparam card_t CARD_KING  = 4'd13;

    localparam score_t DEF_NATURAL_MIN     = 4'd8;
    localparam score_t DEF_PLAYER_DRAW_MAX = 4'd5;

    typedef enum logic [3:0] {
        S_P1, S_D1, S_P2, S_D2, S_NAT, S_P3, S_BNK, S_D3, S_CMP, S_END
    } state_t;

    // Tens and court cards count zero; the empty code also scores zero.
    function automatic score_t face_value(input card_t c);
        return (c >= CARD_ACE && c <= CARD_NINE) ? c : 4'd0;
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// banker_draw_rule: decides whether the dealer takes a third card.
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  score_t dscore,
    input  card_t  pcard3,
    input  logic   player_drew,
    output logic   draw
);

    score_t v;
    logic   table_draw;

    always_comb begin
        v          = face_value(pcard3);
        table_draw = (dscore <= 4'd2) ? 1'b1 :
                     (dscore == 4'd3) ? (v != 4'd8) :
                     (dscore == 4'd4) ? (v >= 4'd2 && v <= 4'd7) :
                     (dscore == 4'd5) ? (v >= 4'd4 && v <= 4'd7) :
                     (dscore == 4'd6) ? (v >= 4'd6 && v <= 4'd7) : 1'b0;
        draw       = player_drew ? table_draw : (dscore <= 4'd5);
    end

endmodule

// File: rtl/deal_sequencer.sv
// deal_sequencer: steps card loads per KEY press, applies baccarat draw rules, drives win lights.
module deal_sequencer
    import baccarat_pkg::*;
#(
    parameter score_t NATURAL_MIN     = DEF_NATURAL_MIN,
    parameter score_t PLAYER_DRAW_MAX = DEF_PLAYER_DRAW_MAX
) (
    input  logic   slow_clock,
    input  logic   reset,
    input  logic   step,
    input  score_t pscore,
    input  score_t dscore,
    input  card_t  pcard3,
    output logic   load_pcard1,
    output logic   load_pcard2,
    output logic   load_pcard3,
    output logic   load_dcard1,
    output logic   load_dcard2,
    output logic   load_dcard3,
    output logic   player_win_light,
    output logic   dealer_win_light,
    output logic   game_over
);

    state_t state_q, state_d;
    logic   drew_q, drew_d;
    logic   pwin_q, pwin_d;
    logic   dwin_q, dwin_d;
    logic   over_q, over_d;
    logic   natural, banker_draw;

    banker_draw_rule u_rule (
        .dscore      (dscore),
        .pcard3      (pcard3),
        .player_drew (drew_q),
        .draw        (banker_draw)
    );

    always_comb begin
        state_d     = state_q;
        drew_d      = drew_q;
        pwin_d      = 1'b0;
        dwin_d      = 1'b0;
        over_d      = 1'b0;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        natural     = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);
        case (state_q)
            S_P1: begin
                load_pcard1 = step;
                drew_d      = 1'b0;
                state_d     = step ? S_D1 : S_P1;
            end
            S_D1: begin
                load_dcard1 = step;
                state_d     = step ? S_P2 : S_D1;
            end
            S_P2: begin
                load_pcard2 = step;
                state_d     = step ? S_D2 : S_P2;
            end
            S_D2: begin
                load_dcard2 = step;
                state_d     = step ? S_NAT : S_D2;
            end
            S_NAT: begin
                drew_d  = !natural && (pscore <= PLAYER_DRAW_MAX);
                state_d = natural ? S_CMP : (pscore <= PLAYER_DRAW_MAX) ? S_P3 : S_BNK;
            end
            S_P3: begin
                load_pcard3 = step;
                state_d     = step ? S_BNK : S_P3;
            end
            S_BNK: state_d = banker_draw ? S_D3 : S_CMP;
            S_D3: begin
                load_dcard3 = step;
                state_d     = step ? S_CMP : S_D3;
            end
            // Equal scores light both, so each light is a >= comparison.
            S_CMP: begin
                pwin_d  = pscore >= dscore;
                dwin_d  = dscore >= pscore;
                over_d  = 1'b1;
                state_d = S_END;
            end
            S_END: begin
                pwin_d = pwin_q;
                dwin_d = dwin_q;
                over_d = 1'b1;
            end
            default: begin
                state_d = S_P1;
                drew_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q <= S_P1;
            drew_q  <= 1'b0;
            pwin_q  <= 1'b0;
            dwin_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drew_q  <= drew_d;
            pwin_q  <= pwin_d;
            dwin_q  <= dwin_d;
            over_q  <= over_d;
        end
    end

    assign player_win_light = pwin_q;
    assign dealer_win_light = dwin_q;
    assign game_over        = over_q;

endmodule

// File: tb/tb_deal_sequencer.sv
// tb_deal_sequencer: random and directed hands against a baccarat rules model with a load/outcome scoreboard.
module tb_deal_sequencer;

    logic       slow_clock = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, game_over;

    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];
    int         loads_seen = 0;
    logic       prev_go = 1'b0;
    logic [1:0] exp_lights;
    int         hand[6];
    int         pc[3];
    int         dc[3];

    deal_sequencer dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .step             (step),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .game_over        (game_over)
    );

    always #5 slow_clock = ~slow_clock;

    function automatic int fv(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic bit banker_draws(input int d, input int v);
        case (d)
            0, 1, 2: return 1'b1;
            3:       return v != 8;
            4:       return v >= 2 && v <= 7;
            5:       return v >= 4 && v <= 7;
            6:       return v >= 6 && v <= 7;
            default: return 1'b0;
        endcase
    endfunction

    // Card registers of the datapath, loaded from the current hand on each load strobe.
    always @(posedge slow_clock) begin
        if (reset) begin
            pc <= '{0, 0, 0};
            dc <= '{0, 0, 0};
        end else begin
            if (load_pcard1) pc[0] <= hand[0];
            if (load_dcard1) dc[0] <= hand[1];
            if (load_pcard2) pc[1] <= hand[2];
            if (load_dcard2) dc[1] <= hand[3];
            if (load_pcard3) pc[2] <= hand[4];
            if (load_dcard3) dc[2] <= hand[5];
        end
    end

    always_comb begin
        pscore = 4'((fv(pc[0]) + fv(pc[1]) + fv(pc[2])) % 10);
        dscore = 4'((fv(dc[0]) + fv(dc[1]) + fv(dc[2])) % 10);
        pcard3 = 4'(pc[2]);
    end

    always @(negedge slow_clock) begin
        logic [5:0] ld;
        int got, want;
        ld = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
        if (!reset) begin
            if (ld != 6'd0) begin
                loads_seen++;
                checks++;
                if ($countones(ld) != 1) begin
                    errors++;
                    $display("FAIL load_onehot: loads=%b, required exactly one", ld);
                end
                got = $clog2(ld);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_order: got load %0d, expected no load", got);
                end else begin
                    want = exp_q.pop_front();
                    if (want != got) begin
                        errors++;
                        $display("FAIL load_order: got load %0d, expected %0d", got, want);
                    end
                end
            end
            if (game_over && !prev_go) begin
                got = 8 + 2 * int'(player_win_light) + int'(dealer_win_light);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL outcome: got %0d, expected nothing pending", got);
                end else begin
                    want = exp_q.pop_front();
                    if (want != got) begin
                        errors++;
                        $display("FAIL outcome: got code %0d, expected %0d", got, want);
                    end
                end
            end
            checks++;
            if (!game_over && (player_win_light || dealer_win_light)) begin
                errors++;
                $display("FAIL lights_early: lights=%b before game_over", {player_win_light, dealer_win_light});
            end
        end
        prev_go = game_over;
    end

    task automatic expect_hand(input int h[6]);
        int  p2, d2, pf, df, v;
        bit  pd, bd;
        p2 = (fv(h[0]) + fv(h[2])) % 10;
        d2 = (fv(h[1]) + fv(h[3])) % 10;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        pf = p2;
        df = d2;
        if (p2 < 8 && d2 < 8) begin
            pd = p2 <= 5;
            v  = fv(h[4]);
            if (pd) begin
                exp_q.push_back(4);
                pf = (p2 + v) % 10;
            end
            bd = pd ? banker_draws(d2, v) : (d2 <= 5);
            if (bd) begin
                exp_q.push_back(5);
                df = (d2 + fv(h[5])) % 10;
            end
        end
        exp_lights = {pf >= df, df >= pf};
        exp_q.push_back(8 + 2 * int'(pf >= df) + int'(df >= pf));
    endtask

    // mode 0: random stepping; 1: hold step low in S_D1 first; 2: reset once in S_P3.
    task automatic run_hand(input int h[6], input int mode);
        int cyc;
        step = 1'b0;
        reset = 1'b1;
        @(posedge slow_clock); #1;
        checks++;
        if ({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
             player_win_light, dealer_win_light, game_over} != 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: outputs not all zero after reset");
        end
        reset = 1'b0;
        exp_q.delete();
        hand = h;
        loads_seen = 0;
        expect_hand(h);
        if (mode == 1) begin
            step = 1'b1;
            @(posedge slow_clock); #1;
            step = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge slow_clock);
                checks++;
                if ({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3} != 6'd0) begin
                    errors++;
                    $display("FAIL step_gating: load seen with step low at cycle %0d", i);
                end
            end
        end
        cyc = 0;
        while (!game_over && cyc < 300) begin
            @(posedge slow_clock); #1;
            cyc++;
            if (mode == 2 && loads_seen >= 4) begin
                step = 1'b0;
                break;
            end
            step = 1'($urandom_range(0, 1));
        end
        if (mode == 2) begin
            @(posedge slow_clock); #1;
            reset = 1'b1;
            @(posedge slow_clock); #1;
            reset = 1'b0;
            checks++;
            if ({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
                 player_win_light, dealer_win_light, game_over} != 9'd0) begin
                errors++;
                $display("FAIL abort_reset: outputs not all zero after mid-hand reset");
            end
            exp_q.delete();
            exp_q.push_back(0);
            step = 1'b1;
            @(negedge slow_clock);
            checks++;
            if (load_pcard1 !== 1'b1) begin
                errors++;
                $display("FAIL abort_first_load: load_pcard1=%b, required 1", load_pcard1);
            end
            @(posedge slow_clock); #1;
            step = 1'b0;
            @(negedge slow_clock);
            return;
        end
        checks++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL timeout: game_over=%b after %0d cycles, required 1", game_over, cyc);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge slow_clock); #1;
            step = 1'($urandom_range(0, 1));
        end
        step = 1'b0;
        @(negedge slow_clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d expected events never seen", exp_q.size());
        end
        checks++;
        if ({game_over, player_win_light, dealer_win_light} != {1'b1, exp_lights}) begin
            errors++;
            $display("FAIL end_hold: go/lights=%b, required %b", {game_over, player_win_light, dealer_win_light}, {1'b1, exp_lights});
        end
    endtask

    initial begin
        int h[6];
        repeat (2) @(posedge slow_clock);
        #1;
        run_hand('{4, 1, 5, 2, 3, 3}, 0);
        run_hand('{3, 2, 4, 2, 9, 4}, 1);
        run_hand('{1, 3, 2, 3, 7, 5}, 0);
        run_hand('{1, 3, 2, 3, 12, 5}, 0);
        run_hand('{2, 2, 3, 3, 10, 1}, 0);
        run_hand('{1, 1, 1, 1, 5, 5}, 2);
        for (int n = 0; n < 40; n++) begin
            foreach (h[i]) h[i] = int'($urandom_range(1, 13));
            run_hand(h, int'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
